// File: rtl/fxp_pkg.sv
// Shared fixed-point constants, divider state encoding and helpers.
package fxp_pkg;

  localparam int Q_WIDTH = 16;
  localparam logic [15:0] Q_MAX = 16'h7FFF;
  localparam logic [15:0] Q_MIN = 16'h8000;
  localparam int DIV_ITER = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // 17 bits so that |-32768| = 32768 is representable.
  function automatic logic [16:0] abs17(input logic signed [15:0] a);
    logic [16:0] ext;
    ext = {a[15], a};
    return a[15] ? (17'd0 - ext) : ext;
  endfunction

endpackage

// File: rtl/fixed_point_divider.sv
// Signed 16-bit fixed-point divider, iterative restoring division with one
// quotient bit per clock and saturating result.
module fixed_point_divider
  import fxp_pkg::*;
#(
  parameter int EXP_WIDTH_A        = 5,
  parameter int EXP_WIDTH_B        = 5,
  parameter int EXP_WIDTH_QUOTIENT = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] quotient,
  output logic        done,
  output logic        busy,
  output logic        div_by_zero
);

  localparam int K = EXP_WIDTH_QUOTIENT - EXP_WIDTH_A + EXP_WIDTH_B;

  generate
    if (K < 0 || K > 15) begin : g_bad_k
      $error("fixed_point_divider: derived shift K out of range 0..15");
    end
  endgenerate

  state_t      state_q;
  logic [4:0]  count_q;
  logic [31:0] dividend_q;
  logic [16:0] divisor_q;
  logic [16:0] rem_q;
  logic [31:0] mag_q;
  logic        sign_q, a_neg_q, a_zero_q, b_zero_q;
  logic [15:0] quotient_q;
  logic        done_q, busy_q, dbz_q;

  logic [17:0] rem_shift_d;
  logic [17:0] diff_d;
  logic        sub_d;
  logic [16:0] rem_d;

  // One restoring step: bring in the next dividend bit, subtract when it fits.
  always_comb begin
    rem_shift_d = {rem_q, dividend_q[31]};
    diff_d      = rem_shift_d - {1'b0, divisor_q};
    sub_d       = ~diff_d[17];
    rem_d       = sub_d ? diff_d[16:0] : rem_shift_d[16:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      mag_q      <= '0;
      sign_q     <= 1'b0;
      a_neg_q    <= 1'b0;
      a_zero_q   <= 1'b0;
      b_zero_q   <= 1'b0;
      quotient_q <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          busy_q <= enable;
          if (enable) begin
            sign_q     <= A[15] ^ B[15];
            a_neg_q    <= A[15];
            a_zero_q   <= (A == 16'd0);
            b_zero_q   <= (B == 16'd0);
            dividend_q <= {15'd0, abs17(A)} << K;
            divisor_q  <= abs17(B);
            rem_q      <= '0;
            mag_q      <= '0;
            count_q    <= '0;
            state_q    <= DIV;
          end
        end
        DIV: begin
          dividend_q <= {dividend_q[30:0], 1'b0};
          rem_q      <= rem_d;
          mag_q      <= {mag_q[30:0], sub_d};
          count_q    <= count_q + 5'd1;
          if (count_q == 5'(DIV_ITER - 1)) state_q <= FIX;
        end
        FIX: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b1;
          state_q <= IDLE;
          if (b_zero_q) begin
            quotient_q <= a_zero_q ? 16'd0 : (a_neg_q ? Q_MIN : Q_MAX);
            dbz_q      <= 1'b1;
          end else begin
            dbz_q <= 1'b0;
            if (!sign_q && mag_q > {16'd0, Q_MAX})
              quotient_q <= Q_MAX;
            else if (sign_q && mag_q > {16'd0, Q_MIN})
              quotient_q <= Q_MIN;
            else
              quotient_q <= sign_q ? (16'd0 - mag_q[15:0]) : mag_q[15:0];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign quotient    = quotient_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fixed_point_divider.sv
// Directed-vector bench for fixed_point_divider (5 fractional bits, 1.0 = 32).
module tb_fixed_point_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] A, B;
  logic [15:0] quotient;
  logic        done, busy, div_by_zero;

  int errors = 0;
  int checks = 0;

  fixed_point_divider dut (
    .clk(clk), .reset(reset), .enable(enable), .A(A), .B(B),
    .quotient(quotient), .done(done), .busy(busy), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Pulse enable for one accepting edge, then count edges until done (bounded).
  task automatic run_div(input logic [15:0] a, input logic [15:0] b, output int lat);
    A = a; B = b; enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    A = 16'hDEAD; B = 16'h0003;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({quotient, done, busy, div_by_zero} !== 19'd0) begin
      errors++;
      $display("FAIL reset_state got q=%h done=%b busy=%b dbz=%b required all 0",
               quotient, done, busy, div_by_zero);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat;
    A = 16'd96; B = 16'd64; enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL busy_after_accept got %b required 1", busy);
    end
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL basic_latency got %0d required 33", lat); end
    checks++;
    if (quotient !== 16'd48 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL basic_96_64 got q=%h dbz=%b required 0030 0", quotient, div_by_zero);
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_done_cycle got %b required 1", busy); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || quotient !== 16'd48) begin
      errors++;
      $display("FAIL after_done got done=%b busy=%b q=%h required 0 0 0030", done, busy, quotient);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic        dbz;
  } vec_t;

  task automatic test_vectors();
    vec_t v[14];
    int lat;
    v[0]  = '{16'hFFA0, 16'd64,   16'hFFD0, 1'b0}; // -3.0 / 2.0
    v[1]  = '{16'd32,   16'hFFA0, 16'hFFF6, 1'b0}; // 1.0 / -3.0, truncation
    v[2]  = '{16'h7FFF, 16'd1,    16'h7FFF, 1'b0};
    v[3]  = '{16'h8000, 16'd1,    16'h8000, 1'b0};
    v[4]  = '{16'h8000, 16'hFFFF, 16'h7FFF, 1'b0};
    v[5]  = '{16'd5,    16'd0,    16'h7FFF, 1'b1};
    v[6]  = '{16'hFFFB, 16'd0,    16'h8000, 1'b1};
    v[7]  = '{16'd0,    16'd0,    16'h0000, 1'b1};
    v[8]  = '{16'd1,    16'd64,   16'h0000, 1'b0}; // underflow, no flag
    v[9]  = '{16'h8000, 16'd32,   16'h8000, 1'b0}; // exact -32768
    v[10] = '{16'h7FFF, 16'd32,   16'h7FFF, 1'b0}; // exact 32767
    v[11] = '{16'h8000, 16'hFFE0, 16'h7FFF, 1'b0}; // +32768 saturates
    v[12] = '{16'hFFFF, 16'd3,    16'hFFF6, 1'b0}; // -1/3 toward zero
    v[13] = '{16'd200,  16'd7,    16'd914,  1'b0}; // 6400/7 = 914
    foreach (v[i]) begin
      run_div(v[i].a, v[i].b, lat);
      checks++;
      if (lat !== 33 || quotient !== v[i].q || div_by_zero !== v[i].dbz) begin
        errors++;
        $display("FAIL vec%0d A=%h B=%h got q=%h dbz=%b lat=%0d required q=%h dbz=%b lat=33",
                 i, v[i].a, v[i].b, quotient, div_by_zero, lat, v[i].q, v[i].dbz);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    // quotient currently non-zero from the previous vector; reset must clear it
    A = 16'd96; B = 16'd64; enable = 1'b1;
    @(posedge clk); #1;  // edge E
    enable = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;  // edge E+10
    reset = 1'b0;
    checks++;
    if (quotient !== 16'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort got q=%h busy=%b done=%b required 0000 0 0", quotient, busy, done);
    end
    @(posedge clk); #1;  // edge E+11
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL abort_no_done got %b required 0", done); end
    run_div(16'd96, 16'd64, lat);  // accepted at E+12
    checks++;
    if (lat !== 33 || quotient !== 16'd48) begin
      errors++; $display("FAIL after_abort got q=%h lat=%0d required 0030 33", quotient, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_enable_during_busy();
    int dones;
    int first;
    A = 16'd96; B = 16'd64; enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    dones = 0; first = -1;
    for (int n = 1; n <= 60; n++) begin
      if (n == 5) begin A = 16'd5; B = 16'd0; enable = 1'b1; end
      if (n == 6) enable = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        dones++;
        if (first < 0) begin
          first = n;
          checks++;
          if (quotient !== 16'd48 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL ignore_enable_result got q=%h dbz=%b required 0030 0", quotient, div_by_zero);
          end
        end
      end
    end
    checks++;
    if (dones !== 1 || first !== 33) begin
      errors++; $display("FAIL ignore_enable_dones got %0d at %0d required 1 at 33", dones, first);
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    A = 16'd96; B = 16'd64; enable = 1'b1;
    @(posedge clk); #1;  // edge E, enable stays high
    A = 16'hFFA0; B = 16'd64;
    t1 = -1; t2 = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done) begin
        if (t1 < 0) begin
          t1 = n;
          checks++;
          if (quotient !== 16'd48) begin
            errors++; $display("FAIL b2b_first got q=%h required 0030", quotient);
          end
          enable = 1'b1;
        end else begin
          t2 = n;
          enable = 1'b0;
          checks++;
          if (quotient !== 16'hFFD0) begin
            errors++; $display("FAIL b2b_second got q=%h required ffd0", quotient);
          end
          break;
        end
      end
    end
    enable = 1'b0;
    checks++;
    if (t1 !== 33 || t2 !== 67) begin
      errors++; $display("FAIL b2b_timing got %0d,%0d required 33,67", t1, t2);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_reset_abort();
    test_enable_during_busy();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
